// File: rtl/vedic_mul16_seq.sv
// Sequential 16x16 unsigned multiplier reusing one combinational vedic_8X8 core over four steps.
// Optional macro VEDIC_SEQ_ZSKIP_EN: zero operands skip the MUL phase and complete immediately.

module vedic_8X8 (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] c
);

  logic [7:0] q_ll, q_lh, q_hl, q_hh;

  // Vedic split: four 4x4 cross products recombined at nibble offsets
  assign q_ll = {4'b0, a[3:0]} * {4'b0, b[3:0]};
  assign q_lh = {4'b0, a[3:0]} * {4'b0, b[7:4]};
  assign q_hl = {4'b0, a[7:4]} * {4'b0, b[3:0]};
  assign q_hh = {4'b0, a[7:4]} * {4'b0, b[7:4]};

  assign c = {8'b0, q_ll} + {4'b0, q_lh, 4'b0} + {4'b0, q_hl, 4'b0} + {q_hh, 8'b0};

endmodule

module vedic_mul16_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] p,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t      state, state_next;
  logic [15:0] ra, rb;
  logic [1:0]  step;
  logic [31:0] acc;
  logic [7:0]  core_a, core_b;
  logic [15:0] core_c;
  logic [31:0] partial;
  logic        zero_op;

`ifdef VEDIC_SEQ_ZSKIP_EN
  assign zero_op = (a == 16'd0) || (b == 16'd0);
`else
  assign zero_op = 1'b0;
`endif

  vedic_8X8 u_core (
    .a (core_a),
    .b (core_b),
    .c (core_c)
  );

  always_comb begin
    core_a = ra[7:0];
    core_b = rb[7:0];
    case (step)
      2'd1:    core_b = rb[15:8];
      2'd2:    core_a = ra[15:8];
      2'd3:    begin core_a = ra[15:8]; core_b = rb[15:8]; end
      default: ;
    endcase
  end

  // Cross terms (steps 1 and 2) share the same 8-bit weight
  always_comb begin
    partial = {16'b0, core_c};
    case (step)
      2'd1, 2'd2: partial = {8'b0, core_c, 8'b0};
      2'd3:       partial = {core_c, 16'b0};
      default:    ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = zero_op ? DONE : MUL;
      end
      MUL: begin
        busy = 1'b1;
        if (step == 2'd3) state_next = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra   <= 16'd0;
      rb   <= 16'd0;
      step <= 2'd0;
      acc  <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            ra   <= a;
            rb   <= b;
            acc  <= 32'd0;
            step <= 2'd0;
          end
        end
        MUL: begin
          acc  <= acc + partial;
          step <= step + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign p = acc;

endmodule

// File: tb/tb_vedic_mul16_seq.sv
// Self-checking bench for vedic_mul16_seq: directed scenarios plus randomized operands checked against a*b.

module tb_vedic_mul16_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = 16'd0;
  logic [15:0] b = 16'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] p;
  logic        busy;

  int tests_run = 0;
  int tests_failed = 0;
  int cycle = 0;

  vedic_mul16_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  // Edges between acceptance and out_valid for an operand pair
  function automatic int exp_latency(input logic [15:0] x, input logic [15:0] y);
`ifdef VEDIC_SEQ_ZSKIP_EN
    if (x == 16'd0 || y == 16'd0) return 0;
`endif
    return 4;
  endfunction

  function automatic logic [31:0] ref_mul(input logic [15:0] x, input logic [15:0] y);
    return 32'(x) * 32'(y);
  endfunction

  // Drives one transaction and reports what it observed; callers compare
  task automatic run_op(input logic [15:0] op_a, input logic [15:0] op_b, input int hold,
                        output logic [31:0] got, output int lat, output bit tmo);
    int n;
    tmo = 1'b0;
    got = 32'd0;
    lat = 0;
    out_ready = 1'b0;
    in_valid = 1'b1;
    a = op_a;
    b = op_b;
    n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!in_ready) begin tmo = 1'b1; in_valid = 1'b0; return; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
    while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    if (!out_valid) begin tmo = 1'b1; return; end
    repeat (hold) @(posedge clk);
    #1;
    got = p;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || p !== 32'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset: in_ready=%b out_valid=%b busy=%b p=%h, required 1 0 0 00000000",
               in_ready, out_valid, busy, p);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_max;
    int n;
    in_valid = 1'b1;
    a = 16'hFFFF;
    b = 16'hFFFF;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin
      tests_run++;
      if (busy !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL max_busy: busy=%b at %0d edges after accept, required 1", busy, n);
      end
      @(posedge clk); #1;
      n++;
    end
    tests_run++;
    if (n !== 4) begin
      tests_failed++;
      $display("[TB] FAIL max_latency: got %0d edges, required 4", n);
    end
    tests_run++;
    if (p !== 32'hFFFE0001 || busy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL max_product: p=%h busy=%b, required fffe0001 1", p, busy);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL max_handshake: busy=%b in_ready=%b out_valid=%b, required 0 1 0",
               busy, in_ready, out_valid);
    end
  endtask

  task automatic test_backpressure;
    int n;
    logic [31:0] expv;
    expv = ref_mul(16'd1234, 16'd5678);
    in_valid = 1'b1;
    a = 16'd1234;
    b = 16'd5678;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
    tests_run++;
    if (out_valid !== 1'b1 || p !== 32'h006AE9BC || expv !== 32'h006AE9BC) begin
      tests_failed++;
      $display("[TB] FAIL bp_product: out_valid=%b p=%h, required 1 %h", out_valid, p, expv);
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      tests_run++;
      if (out_valid !== 1'b1 || p !== expv || in_ready !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL bp_hold: cycle %0d out_valid=%b p=%h in_ready=%b, required 1 %h 0",
                 i, out_valid, p, in_ready, expv);
      end
    end
    out_ready = 1'b1;
    #1;
    tests_run++;
    if (in_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL bp_ready_early: in_ready=%b before handshake edge, required 0", in_ready);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL bp_release: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_back_to_back;
    int n, t1, t2;
    out_ready = 1'b1;
    in_valid = 1'b1;
    a = 16'h00FF;
    b = 16'h00FF;
    @(posedge clk);
    t1 = cycle;
    #1;
    a = 16'h0018;
    b = 16'h002A;
    n = 0;
    while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
    tests_run++;
    if (p !== 32'h0000FE01) begin
      tests_failed++;
      $display("[TB] FAIL b2b_first: p=%h, required 0000fe01", p);
    end
    n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk);
    t2 = cycle;
    #1;
    in_valid = 1'b0;
    tests_run++;
    if (t2 - t1 !== 6) begin
      tests_failed++;
      $display("[TB] FAIL b2b_spacing: accepts %0d cycles apart, required 6", t2 - t1);
    end
    n = 0;
    while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
    tests_run++;
    if (out_valid !== 1'b1 || p !== 32'h000003F0) begin
      tests_failed++;
      $display("[TB] FAIL b2b_second: out_valid=%b p=%h, required 1 000003f0", out_valid, p);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_zero;
    logic [31:0] got;
    int lat;
    bit tmo;
    run_op(16'h0000, 16'h1234, 0, got, lat, tmo);
    tests_run++;
    if (tmo || got !== 32'd0 || lat !== exp_latency(16'h0000, 16'h1234)) begin
      tests_failed++;
      $display("[TB] FAIL zero_operand: timeout=%0d p=%h latency=%0d, required 0 00000000 %0d",
               tmo, got, lat, exp_latency(16'h0000, 16'h1234));
    end
  endtask

  task automatic test_abort;
    logic [31:0] got;
    int lat;
    bit tmo;
    in_valid = 1'b1;
    a = 16'h0F0F;
    b = 16'h0D0D;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || p !== 32'd0) begin
      tests_failed++;
      $display("[TB] FAIL abort_reset: in_ready=%b out_valid=%b busy=%b p=%h, required 1 0 0 00000000",
               in_ready, out_valid, busy, p);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(16'h0017, 16'h0031, 0, got, lat, tmo);
    tests_run++;
    if (tmo || got !== 32'h00000467 || lat !== 4) begin
      tests_failed++;
      $display("[TB] FAIL abort_next: timeout=%0d p=%h latency=%0d, required 0 00000467 4", tmo, got, lat);
    end
  endtask

  task automatic test_hold_changing;
    int n;
    logic [15:0] xa, xb;
    xa = 16'($urandom_range(1, 65535));
    xb = 16'($urandom_range(1, 65535));
    out_ready = 1'b1;
    in_valid = 1'b1;
    a = xa;
    b = xb;
    @(posedge clk); #1;
    n = 0;
    while (!out_valid && n < 50) begin
      a = 16'($urandom);
      b = 16'($urandom);
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    tests_run++;
    if (p !== ref_mul(xa, xb) || n !== 4) begin
      tests_failed++;
      $display("[TB] FAIL hold_changing: p=%h latency=%0d, required %h 4", p, n, ref_mul(xa, xb));
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_random;
    logic [15:0] xa, xb;
    logic [31:0] got;
    int lat;
    bit tmo;
    for (int i = 0; i < 24; i++) begin
      xa = 16'($urandom);
      xb = 16'($urandom);
      if ($urandom_range(0, 5) == 0) xa = 16'd0;
      if ($urandom_range(0, 5) == 0) xb = 16'd0;
      run_op(xa, xb, int'($urandom_range(0, 3)), got, lat, tmo);
      tests_run++;
      if (tmo || got !== ref_mul(xa, xb) || lat !== exp_latency(xa, xb)) begin
        tests_failed++;
        $display("[TB] FAIL random_%0d: a=%h b=%h timeout=%0d p=%h latency=%0d, required %h %0d",
                 i, xa, xb, tmo, got, lat, ref_mul(xa, xb), exp_latency(xa, xb));
      end
    end
  endtask

  initial begin
    test_reset;
    test_max;
    test_backpressure;
    test_back_to_back;
    test_zero;
    test_abort;
    test_hold_changing;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
